// File: rtl/id_ex_hazard_unit_pkg.sv
// Shared pipeline definitions for the ID/EX hazard controller.
//   hz_state_e : front-end sequencing state (RUN / MC_BUSY)
//   EX_W/M_W/WB_W : default widths of the EX, MEM and WB control fields
//   REG_ZERO   : architectural zero register. It never carries a real dependency.
package id_ex_hazard_unit_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  localparam int EX_W = 7;
  localparam int M_W  = 4;
  localparam int WB_W = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The source operand depends on the load only when it is actually read.
  function automatic logic src_hit(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_hazard_unit_cnt_sat.sv
// hazard_cnt_sat: W-bit up counter with enable.
// It stops at all-ones and does not wrap.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset, clears count
//   en    in  count this cycle
//   count out current value
module hazard_cnt_sat #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (en && (count != '1))  count <= count + W'(1);
  end

endmodule

// File: rtl/id_ex_hazard_unit.sv
// id_ex_hazard_unit: controls the writer side of the ID/EX pipeline register.
// Each cycle, ID/EX does one of three things:
//   - capture the decoded instruction,
//   - capture a bubble (all control fields zero),
//   - hold its current contents.
// The unit handles three hazard cases:
//   - load-use stalls,
//   - taken-branch flushes,
//   - multi-cycle EX occupancy (mult/div).
// It also drives the PC, IF/ID and EX/MEM controls.
// Ports:
//   clk, rst                   clock, async active-high reset
//   id_rs/id_rt/id_uses_rs/rt  source operands of the instruction in ID
//   id_ctrl_ex/_m/_wb          decoded control fields
//   idex_mem_read, idex_rt     load currently in ID/EX and its destination register
//   ex_branch_taken            branch resolved taken in EX
//   ex_mc_start                one-cycle pulse: a multi-cycle op entered EX
//   pc_write_en, ifid_write_en, ifid_flush, idex_write_en  front-end enables
//   idex_ctrl_ex/_m/_wb        control written into ID/EX (zero on a bubble)
//   exmem_bubble               EX/MEM captures zero control
//   mc_busy                    multi-cycle op in progress
//   stall_cycles               saturating count of cycles with pc_write_en=0
module id_ex_hazard_unit
  import id_ex_hazard_unit_pkg::hz_state_e, id_ex_hazard_unit_pkg::RUN,
         id_ex_hazard_unit_pkg::MC_BUSY, id_ex_hazard_unit_pkg::REG_ZERO,
         id_ex_hazard_unit_pkg::src_hit;
#(
  parameter int MC_LATENCY = 4,  // must be >= 2
  parameter int CNT_W      = 32,
  parameter int EX_W       = id_ex_hazard_unit_pkg::EX_W,
  parameter int M_W        = id_ex_hazard_unit_pkg::M_W,
  parameter int WB_W       = id_ex_hazard_unit_pkg::WB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [EX_W-1:0]  id_ctrl_ex,
  input  logic [M_W-1:0]   id_ctrl_m,
  input  logic [WB_W-1:0]  id_ctrl_wb,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_write_en,
  output logic [EX_W-1:0]  idex_ctrl_ex,
  output logic [M_W-1:0]   idex_ctrl_m,
  output logic [WB_W-1:0]  idex_ctrl_wb,
  output logic             exmem_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MC_W = $clog2(MC_LATENCY + 1);

  hz_state_e       state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic            load_use;

  assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                    (src_hit(id_uses_rs, id_rs, idex_rt) || src_hit(id_uses_rt, id_rt, idex_rt));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Next state. The start cycle is the first freeze cycle, so
  // MC_LATENCY-1 cycles remain in MC_BUSY.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      RUN: begin
        if (!ex_branch_taken && ex_mc_start) begin
          state_d  = MC_BUSY;
          mc_cnt_d = MC_W'(MC_LATENCY - 1);
        end
      end
      MC_BUSY: begin
        if (mc_cnt_q == MC_W'(1)) begin
          state_d  = RUN;
          mc_cnt_d = '0;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_W'(1);
        end
      end
      default: begin
        state_d  = RUN;
        mc_cnt_d = '0;
      end
    endcase
  end

  // Outputs. On the last MC_BUSY cycle (mc_cnt==1), EX/MEM takes the result.
  // The front end stays frozen for that cycle, so the total freeze is
  // MC_LATENCY cycles. Write enables return when the state is back in RUN.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_write_en = 1'b1;
    idex_ctrl_ex  = id_ctrl_ex;
    idex_ctrl_m   = id_ctrl_m;
    idex_ctrl_wb  = id_ctrl_wb;
    exmem_bubble  = 1'b0;
    mc_busy       = 1'b0;
    if (rst) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_write_en = 1'b0;
      idex_ctrl_ex  = '0;
      idex_ctrl_m   = '0;
      idex_ctrl_wb  = '0;
      exmem_bubble  = 1'b1;
    end else if (state_q == MC_BUSY) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_write_en = 1'b0;
      idex_ctrl_ex  = '0;
      idex_ctrl_m   = '0;
      idex_ctrl_wb  = '0;
      exmem_bubble  = (mc_cnt_q != MC_W'(1));
      mc_busy       = 1'b1;
    end else if (ex_branch_taken) begin
      // Kill both wrong-path instructions: IF/ID gets a NOP, ID/EX gets a bubble.
      ifid_flush    = 1'b1;
      idex_ctrl_ex  = '0;
      idex_ctrl_m   = '0;
      idex_ctrl_wb  = '0;
    end else if (ex_mc_start) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_write_en = 1'b0;
      idex_ctrl_ex  = '0;
      idex_ctrl_m   = '0;
      idex_ctrl_wb  = '0;
      exmem_bubble  = 1'b1;
    end else if (load_use) begin
      // The bubble enters ID/EX, which clears idex_mem_read.
      // This limits the stall to a single cycle.
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_ctrl_ex  = '0;
      idex_ctrl_m   = '0;
      idex_ctrl_wb  = '0;
    end
  end

  hazard_cnt_sat #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (~pc_write_en),
    .count (stall_cycles)
  );

  // A multi-cycle start that coincides with a taken branch is a wrong-path op.
  // The branch wins; this case should never happen in a correct decoder.
  a_no_branch_mc: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN && ex_branch_taken) |-> !ex_mc_start);

  a_uses_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({id_uses_rs, id_uses_rt}));

endmodule
